// File: rtl/naneye_link_ctrl_if.sv
// -----------------------------------------------------------------------------
// naneye_link_ctrl_if
//
// Signal bundle between the NanEye link session controller and its
// environment (config transmitter, frame decoder, sensor supply switch).
//
// Handshake semantics: every input and output is a level or a single-cycle
// pulse sampled on the rising system clock. No valid/ready pairing exists;
// a pulse is consumed in the cycle it is high, or is ignored if the
// controller is in a state that does not listen for it.
//
// Signals:
//   ENABLE        level,   1 = run the link, 0 = shut down
//   CFG_REQ       pulse,   reconfigure the sensor without a power cycle
//   CONFIG_DONE   pulse,   end of configuration transmission
//   FRAME_START   pulse,   start of a received frame
//   ERROR_IN      pulse,   decoder / deserializer error
//   SENSOR_PWR_EN level,   sensor supply enable
//   CONFIG_EN     pulse,   start the configuration transmitter
//   LINK_UP       level,   link qualified and running
//   FAULT         level,   retries exhausted
//   STATE         [2:0],   controller state (debug / supervision)
//   FRAME_CNT     [15:0],  frames seen while running
//   RETRY_CNT     [3:0],   failed attempts since the link last came up
//
// Modports:
//   master - the environment (drives the inputs, observes the outputs)
//   slave  - the controller
// -----------------------------------------------------------------------------
interface naneye_link_ctrl_if;
   logic        ENABLE;
   logic        CFG_REQ;
   logic        CONFIG_DONE;
   logic        FRAME_START;
   logic        ERROR_IN;
   logic        SENSOR_PWR_EN;
   logic        CONFIG_EN;
   logic        LINK_UP;
   logic        FAULT;
   logic [2:0]  STATE;
   logic [15:0] FRAME_CNT;
   logic [3:0]  RETRY_CNT;

   modport master (
      output ENABLE, CFG_REQ, CONFIG_DONE, FRAME_START, ERROR_IN,
      input  SENSOR_PWR_EN, CONFIG_EN, LINK_UP, FAULT, STATE, FRAME_CNT, RETRY_CNT
   );

   modport slave (
      input  ENABLE, CFG_REQ, CONFIG_DONE, FRAME_START, ERROR_IN,
      output SENSOR_PWR_EN, CONFIG_EN, LINK_UP, FAULT, STATE, FRAME_CNT, RETRY_CNT
   );
endinterface

// File: rtl/naneye_link_ctrl.sv
// -----------------------------------------------------------------------------
// naneye_link_ctrl
//
// Session controller for one NanEye 2D sensor link. Sequences sensor
// power-up, launches the configuration transmitter, qualifies the link on
// the first frame, then supervises it with a frame watchdog and a per-frame
// error limit. Failures power-cycle and reconfigure the sensor until the
// retry budget is spent, after which FAULT is latched until ENABLE drops.
//
// Ports:
//   CLOCK    system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   link     naneye_link_ctrl_if.slave (inputs ENABLE, CFG_REQ, CONFIG_DONE,
//            FRAME_START, ERROR_IN; outputs SENSOR_PWR_EN, CONFIG_EN,
//            LINK_UP, FAULT, STATE, FRAME_CNT, RETRY_CNT)
//
// All outputs come straight from registers or from a decode of the state
// register, so they change one cycle after the edge that caused them.
// -----------------------------------------------------------------------------
module naneye_link_ctrl #(
   parameter int unsigned C_PWR_CYC      = 4800,
   parameter int unsigned C_CFG_TO_CYC   = 48000,
   parameter int unsigned C_FRAME_TO_CYC = 2400000,
   parameter int unsigned C_ERR_LIMIT    = 4,
   parameter int unsigned C_MAX_RETRY    = 3
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   naneye_link_ctrl_if.slave  link
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PWROFF     = 3'd1,
      S_PWRUP      = 3'd2,
      S_CONFIG     = 3'd3,
      S_WAIT_FRAME = 3'd4,
      S_RUN        = 3'd5,
      S_FAULT      = 3'd6
   } state_t;

   // A load of N-1 makes a state last exactly N cycles: expiry is the cycle
   // in which the timer reads zero.
   localparam logic [23:0] PWR_LOAD   = 24'(C_PWR_CYC - 1);
   localparam logic [23:0] CFG_LOAD   = 24'(C_CFG_TO_CYC - 1);
   localparam logic [23:0] FRAME_LOAD = 24'(C_FRAME_TO_CYC - 1);
   localparam logic [4:0]  ERR_LIMIT  = 5'(C_ERR_LIMIT);
   localparam logic [3:0]  MAX_RETRY  = 4'(C_MAX_RETRY);

   state_t      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [3:0]  err_q, err_d;
   logic [3:0]  retry_q, retry_d;
   logic [15:0] frame_q, frame_d;
   logic        cfg_en_q, cfg_en_d;

   logic        expired;
   logic        fail;
   logic [4:0]  err_inc;
   logic        err_limit_hit;

   assign expired       = (timer_q == 24'd0);
   assign err_inc       = {1'b0, err_q} + 5'd1;
   // An error coincident with a frame start belongs to the new frame and is
   // handled by the frame-start reload, so it never trips the limit here.
   assign err_limit_hit = link.ERROR_IN && !link.FRAME_START && (err_inc >= ERR_LIMIT);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         err_q    <= '0;
         retry_q  <= '0;
         frame_q  <= '0;
         cfg_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         retry_q  <= retry_d;
         frame_q  <= frame_d;
         cfg_en_q <= cfg_en_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = expired ? 24'd0 : (timer_q - 24'd1);
      err_d    = err_q;
      retry_d  = retry_q;
      frame_d  = frame_q;
      cfg_en_d = 1'b0;
      fail     = 1'b0;

      if (!link.ENABLE) begin
         // Shutdown overrides everything; IDLE presents all outputs low.
         state_d = S_IDLE;
         timer_d = '0;
         err_d   = '0;
         retry_d = '0;
         frame_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_PWRUP;
               timer_d = PWR_LOAD;
               err_d   = '0;
               retry_d = '0;
               frame_d = '0;
            end
            S_PWROFF: begin
               if (expired) begin
                  state_d = S_PWRUP;
                  timer_d = PWR_LOAD;
               end
            end
            S_PWRUP: begin
               if (expired) begin
                  state_d  = S_CONFIG;
                  timer_d  = CFG_LOAD;
                  cfg_en_d = 1'b1;
               end
            end
            S_CONFIG: begin
               if (expired) begin
                  fail = 1'b1;
               end else if (link.CONFIG_DONE) begin
                  state_d = S_WAIT_FRAME;
                  timer_d = FRAME_LOAD;
               end
            end
            S_WAIT_FRAME: begin
               if (expired) begin
                  fail = 1'b1;
               end else if (link.FRAME_START) begin
                  state_d = S_RUN;
                  timer_d = FRAME_LOAD;
                  err_d   = '0;
                  retry_d = '0;
                  frame_d = frame_q + 16'd1;
               end
            end
            S_RUN: begin
               if (expired || err_limit_hit) begin
                  fail = 1'b1;
               end else if (link.CFG_REQ) begin
                  // Reconfigure with the supply left on.
                  state_d  = S_CONFIG;
                  timer_d  = CFG_LOAD;
                  cfg_en_d = 1'b1;
               end else if (link.FRAME_START) begin
                  timer_d = FRAME_LOAD;
                  frame_d = frame_q + 16'd1;
                  err_d   = {3'b000, link.ERROR_IN};
               end else if (link.ERROR_IN) begin
                  err_d = err_inc[3:0];
               end
            end
            S_FAULT: begin
               timer_d = '0;
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase

         if (fail) begin
            retry_d = retry_q + 4'd1;
            if (retry_d == MAX_RETRY) begin
               state_d = S_FAULT;
               timer_d = '0;
            end else begin
               state_d = S_PWROFF;
               timer_d = PWR_LOAD;
            end
         end
      end
   end

   assign link.SENSOR_PWR_EN = (state_q == S_PWRUP) || (state_q == S_CONFIG) ||
                               (state_q == S_WAIT_FRAME) || (state_q == S_RUN);
   assign link.CONFIG_EN     = cfg_en_q;
   assign link.LINK_UP       = (state_q == S_RUN);
   assign link.FAULT         = (state_q == S_FAULT);
   assign link.STATE         = state_q;
   assign link.FRAME_CNT     = frame_q;
   assign link.RETRY_CNT     = retry_q;

endmodule

// File: tb/tb_naneye_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_naneye_link_ctrl
//
// Bench for naneye_link_ctrl with small timing parameters. A reference model
// tracks the session using absolute cycle deadlines, pushes the expected
// output word for every clock into exp_q, and a compare process pops and
// checks it on the falling edge. Directed scenarios add hand-computed
// latencies and counter values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_naneye_link_ctrl;

   localparam int unsigned P_PWR   = 8;
   localparam int unsigned P_CFG   = 20;
   localparam int unsigned P_FRAME = 50;
   localparam int unsigned P_ERR   = 3;
   localparam int unsigned P_RETRY = 2;

   localparam int ST_IDLE = 0, ST_PWROFF = 1, ST_PWRUP = 2, ST_CONFIG = 3;
   localparam int ST_WAIT = 4, ST_RUN = 5, ST_FAULT = 6;

   localparam int W = 27;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   naneye_link_ctrl_if link_if ();

   naneye_link_ctrl #(
      .C_PWR_CYC      (P_PWR),
      .C_CFG_TO_CYC   (P_CFG),
      .C_FRAME_TO_CYC (P_FRAME),
      .C_ERR_LIMIT    (P_ERR),
      .C_MAX_RETRY    (P_RETRY)
   ) dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .link    (link_if)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("time limit reached before the summary");
      $fatal(1, "simulation time limit");
   end

   // ---------------- reference model ----------------
   // Time is measured in absolute cycles; a timed state entered at cycle t
   // with duration N expires on the clock whose cycle number is t+N.
   longint      m_cyc      = 0;
   longint      m_deadline = 0;
   int          m_state    = ST_IDLE;
   logic [15:0] m_frames   = '0;
   int          m_retry    = 0;
   int          m_errs     = 0;
   logic        m_cfg_en   = 1'b0;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] pack_model();
      logic pwr;
      pwr = (m_state == ST_PWRUP) || (m_state == ST_CONFIG) ||
            (m_state == ST_WAIT) || (m_state == ST_RUN);
      return {pwr, m_cfg_en, (m_state == ST_RUN), (m_state == ST_FAULT),
              3'(m_state), m_frames, 4'(m_retry)};
   endfunction

   function automatic logic [W-1:0] pack_dut();
      return {link_if.SENSOR_PWR_EN, link_if.CONFIG_EN, link_if.LINK_UP, link_if.FAULT,
              link_if.STATE, link_if.FRAME_CNT, link_if.RETRY_CNT};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_deadline = 0; m_state = ST_IDLE; m_frames = '0;
         m_retry = 0; m_errs = 0; m_cfg_en = 1'b0;
         exp_q.delete();
      end else begin
         logic expired;
         logic failed;
         m_cyc    = m_cyc + 1;
         m_cfg_en = 1'b0;
         expired  = (m_cyc == m_deadline);
         failed   = 1'b0;
         if (!link_if.ENABLE) begin
            m_state = ST_IDLE; m_frames = '0; m_retry = 0; m_errs = 0;
         end else begin
            case (m_state)
               ST_IDLE: begin
                  m_state = ST_PWRUP; m_deadline = m_cyc + P_PWR;
                  m_frames = '0; m_retry = 0; m_errs = 0;
               end
               ST_PWROFF: if (expired) begin
                  m_state = ST_PWRUP; m_deadline = m_cyc + P_PWR;
               end
               ST_PWRUP: if (expired) begin
                  m_state = ST_CONFIG; m_deadline = m_cyc + P_CFG; m_cfg_en = 1'b1;
               end
               ST_CONFIG: begin
                  if (expired) failed = 1'b1;
                  else if (link_if.CONFIG_DONE) begin
                     m_state = ST_WAIT; m_deadline = m_cyc + P_FRAME;
                  end
               end
               ST_WAIT: begin
                  if (expired) failed = 1'b1;
                  else if (link_if.FRAME_START) begin
                     m_state = ST_RUN; m_deadline = m_cyc + P_FRAME;
                     m_retry = 0; m_errs = 0; m_frames = m_frames + 16'd1;
                  end
               end
               ST_RUN: begin
                  if (expired) failed = 1'b1;
                  else if (link_if.ERROR_IN && !link_if.FRAME_START && (m_errs + 1 >= P_ERR))
                     failed = 1'b1;
                  else if (link_if.CFG_REQ) begin
                     m_state = ST_CONFIG; m_deadline = m_cyc + P_CFG; m_cfg_en = 1'b1;
                  end else if (link_if.FRAME_START) begin
                     m_deadline = m_cyc + P_FRAME; m_frames = m_frames + 16'd1;
                     m_errs = link_if.ERROR_IN ? 1 : 0;
                  end else if (link_if.ERROR_IN) begin
                     m_errs = m_errs + 1;
                  end
               end
               default: ;
            endcase
            if (failed) begin
               m_retry = m_retry + 1;
               if (m_retry == P_RETRY) m_state = ST_FAULT;
               else begin
                  m_state = ST_PWROFF; m_deadline = m_cyc + P_PWR;
               end
            end
         end
         exp_q.push_back(pack_model());
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         logic [W-1:0] exp_w;
         logic [W-1:0] act_w;
         exp_w = exp_q.pop_front();
         act_w = pack_dut();
         n_checks = n_checks + 1;
         if (act_w !== exp_w) begin
            n_errors = n_errors + 1;
            $display("FAIL outputs @%0t: got pwr=%b cfg=%b up=%b flt=%b st=%0d frm=%0d rty=%0d, expected pwr=%b cfg=%b up=%b flt=%b st=%0d frm=%0d rty=%0d",
                     $time, act_w[26], act_w[25], act_w[24], act_w[23], act_w[22:20], act_w[19:4], act_w[3:0],
                     exp_w[26], exp_w[25], exp_w[24], exp_w[23], exp_w[22:20], exp_w[19:4], exp_w[3:0]);
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_done();
      link_if.CONFIG_DONE = 1'b1; @(negedge clk); link_if.CONFIG_DONE = 1'b0;
   endtask

   task automatic pulse_frame();
      link_if.FRAME_START = 1'b1; @(negedge clk); link_if.FRAME_START = 1'b0;
   endtask

   task automatic pulse_err();
      link_if.ERROR_IN = 1'b1; @(negedge clk); link_if.ERROR_IN = 1'b0;
   endtask

   task automatic pulse_cfg();
      link_if.CFG_REQ = 1'b1; @(negedge clk); link_if.CFG_REQ = 1'b0;
   endtask

   localparam int P_CFG_EN = 0, P_LINK_LOW = 1, P_FAULT = 2, P_STATE = 3;

   function automatic logic probe(input int sel, input int val);
      case (sel)
         P_CFG_EN:   return link_if.CONFIG_EN;
         P_LINK_LOW: return !link_if.LINK_UP;
         P_FAULT:    return link_if.FAULT;
         default:    return (link_if.STATE == 3'(val));
      endcase
   endfunction

   // Counts falling edges until the probe holds; an expired budget is a
   // failed comparison.
   task automatic wait_for(input string name, input int sel, input int val,
                           input int budget, output int cycles);
      cycles = 0;
      while (!probe(sel, val) && cycles < budget) begin
         @(negedge clk);
         cycles = cycles + 1;
      end
      if (!probe(sel, val)) begin
         n_checks = n_checks + 1;
         n_errors = n_errors + 1;
         $display("FAIL %s: no event within %0d cycles", name, budget);
      end
   endtask

   task automatic bring_up(input string name);
      int c;
      wait_for({name, " config_en"}, P_CFG_EN, 0, 60, c);
      tick(2);
      pulse_done();
      tick(3);
      pulse_frame();
      check({name, " link_up"}, int'(link_if.LINK_UP), 1);
   endtask

   task automatic shutdown_check(input string name, input int st);
      check({name, " state before"}, int'(link_if.STATE), st);
      link_if.ENABLE = 1'b0;
      tick(1);
      check({name, " state idle"}, int'(link_if.STATE), ST_IDLE);
      check({name, " flags"}, int'({link_if.SENSOR_PWR_EN, link_if.CONFIG_EN,
                                    link_if.LINK_UP, link_if.FAULT}), 0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int c;
      int pulses;
      int pwr_drop;

      rst_n = 1'b1;
      link_if.ENABLE = 1'b0; link_if.CFG_REQ = 1'b0; link_if.CONFIG_DONE = 1'b0;
      link_if.FRAME_START = 1'b0; link_if.ERROR_IN = 1'b0;
      #1 rst_n = 1'b0;
      tick(3);
      check("reset outputs", int'(pack_dut()), 0);
      rst_n = 1'b1;
      tick(2);
      check("idle after reset", int'(link_if.STATE), ST_IDLE);

      // Nominal bring-up
      link_if.ENABLE = 1'b1;
      wait_for("nominal config_en", P_CFG_EN, 0, 40, c);
      check("enable to config_en", c, 9);
      check("config state", int'(link_if.STATE), ST_CONFIG);
      tick(1);
      check("config_en one cycle", int'(link_if.CONFIG_EN), 0);
      tick(4);
      pulse_done();
      check("wait_frame state", int'(link_if.STATE), ST_WAIT);
      tick(9);
      pulse_frame();
      check("nominal link_up", int'(link_if.LINK_UP), 1);
      check("nominal frame_cnt", int'(link_if.FRAME_CNT), 1);
      check("nominal retry_cnt", int'(link_if.RETRY_CNT), 0);

      // Watchdog: frames every 40 cycles keep RUN, then stop
      for (int i = 0; i < 4; i++) begin
         tick(39);
         pulse_frame();
      end
      check("watchdog held", int'(link_if.LINK_UP), 1);
      check("watchdog frames", int'(link_if.FRAME_CNT), 5);
      wait_for("watchdog drop", P_LINK_LOW, 0, 100, c);
      check("watchdog latency", c, 50);
      check("watchdog pwroff", int'(link_if.STATE), ST_PWROFF);
      check("watchdog retry", int'(link_if.RETRY_CNT), 1);
      bring_up("after watchdog");

      // Error limit
      pulse_err(); tick(2); pulse_err(); tick(2);
      pulse_frame(); tick(2);
      pulse_err(); tick(2); pulse_err(); tick(2);
      check("2+frame+2 errors keep run", int'(link_if.STATE), ST_RUN);
      pulse_frame(); tick(2);
      pulse_err(); tick(2); pulse_err(); tick(2);
      check("two errors keep link", int'(link_if.LINK_UP), 1);
      pulse_err();
      check("third error pwroff", int'(link_if.STATE), ST_PWROFF);
      check("third error link down", int'(link_if.LINK_UP), 0);
      check("error retry", int'(link_if.RETRY_CNT), 1);
      bring_up("after errors");
      check("frames before reconfig", int'(link_if.FRAME_CNT), 9);

      // Reconfigure from RUN
      tick(3);
      pulse_cfg();
      check("reconfig state", int'(link_if.STATE), ST_CONFIG);
      check("reconfig frames kept", int'(link_if.FRAME_CNT), 9);
      pulses = 0;
      pwr_drop = 0;
      for (int i = 0; i < 6; i++) begin
         pulses   = pulses + int'(link_if.CONFIG_EN);
         pwr_drop = pwr_drop + int'(!link_if.SENSOR_PWR_EN);
         tick(1);
      end
      check("reconfig config_en pulses", pulses, 1);
      check("reconfig power kept", pwr_drop, 0);
      pulse_done();
      tick(2);
      pulse_frame();
      check("reconfig link_up", int'(link_if.LINK_UP), 1);
      check("reconfig frame increments", int'(link_if.FRAME_CNT), 10);

      // Aborts
      tick(2);
      shutdown_check("abort run", ST_RUN);
      link_if.ENABLE = 1'b1;
      tick(3);
      shutdown_check("abort pwrup", ST_PWRUP);
      link_if.ENABLE = 1'b1;
      wait_for("abort config_en", P_CFG_EN, 0, 40, c);
      tick(2);
      shutdown_check("abort config", ST_CONFIG);

      // Config timeout, retry and fault
      tick(2);
      link_if.ENABLE = 1'b1;
      wait_for("timeout config_en", P_CFG_EN, 0, 40, c);
      wait_for("config timeout", P_STATE, ST_PWROFF, 60, c);
      check("config duration", c, 20);
      check("pwroff power", int'(link_if.SENSOR_PWR_EN), 0);
      check("timeout retry 1", int'(link_if.RETRY_CNT), 1);
      wait_for("pwroff end", P_STATE, ST_PWRUP, 30, c);
      check("pwroff duration", c, 8);
      wait_for("fault", P_FAULT, 0, 60, c);
      check("pwrup+config before fault", c, 28);
      check("fault retry", int'(link_if.RETRY_CNT), 2);
      check("fault power", int'(link_if.SENSOR_PWR_EN), 0);
      tick(5);
      check("fault holds", int'(link_if.STATE), ST_FAULT);
      shutdown_check("fault exit", ST_FAULT);

      // Asynchronous reset mid-timer
      link_if.ENABLE = 1'b1;
      tick(4);
      check("pre-reset power", int'(link_if.SENSOR_PWR_EN), 1);
      #2 rst_n = 1'b0;
      #1 check("async reset outputs", int'(pack_dut()), 0);
      link_if.ENABLE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // Randomized phase against the model
      for (int i = 0; i < 4000; i++) begin
         link_if.ENABLE      = ($urandom_range(0, 299) != 0);
         link_if.CONFIG_DONE = ($urandom_range(0, 24) == 0);
         link_if.FRAME_START = ($urandom_range(0, 44) == 0);
         link_if.ERROR_IN    = ($urandom_range(0, 39) == 0);
         link_if.CFG_REQ     = ($urandom_range(0, 199) == 0);
         tick(1);
      end
      link_if.ENABLE = 1'b0; link_if.CONFIG_DONE = 1'b0; link_if.FRAME_START = 1'b0;
      link_if.ERROR_IN = 1'b0; link_if.CFG_REQ = 1'b0;
      tick(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/naneye_link_ctrl.md
# naneye_link_ctrl

Session controller for one NanEye 2D sensor link, in the 48 MHz system-clock domain. It sequences sensor power-up, launches the configuration transmitter and waits for its completion. It then qualifies the link on the first received frame and supervises it with a frame watchdog and an error-rate limit. On failure it power-cycles and reconfigures the sensor, up to a bounded retry count, before latching a fault.

## Interface
Parameters:
- C_PWR_CYC, default 4800: power-off and power-up settle time in cycles (100 µs at 48 MHz).
- C_CFG_TO_CYC, default 48000: CONFIG_DONE timeout in cycles.
- C_FRAME_TO_CYC, default 2400000: frame watchdog in cycles (50 ms); also the first-frame timeout.
- C_ERR_LIMIT, default 4: ERROR_IN pulses within one frame that force a retry (1..15).
- C_MAX_RETRY, default 3: consecutive failed attempts before FAULT (1..15).

All cycle parameters are 1..2^24-1. A single 24-bit timer serves every state.

Ports:
- CLOCK  in  1  48 MHz system clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  level; 1 = run the link, 0 = shut down.
- CFG_REQ  in  1  1-cycle pulse; reconfigure the sensor without a power cycle.
- CONFIG_DONE  in  1  1-cycle pulse from the config transmitter (TX_END).
- FRAME_START  in  1  1-cycle pulse, already synchronised to CLOCK.
- ERROR_IN  in  1  1-cycle pulse, OR of decoder and deserializer errors, synchronised.
- SENSOR_PWR_EN  out  1  sensor supply enable.
- CONFIG_EN  out  1  1-cycle start pulse to the config transmitter.
- LINK_UP  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- STATE  out  3  encoded state: IDLE=0, PWROFF=1, PWRUP=2, CONFIG=3, WAIT_FRAME=4, RUN=5, FAULT=6.
- FRAME_CNT  out  16  frames seen in RUN; wraps at 0xFFFF→0.
- RETRY_CNT  out  4  failed attempts since the last entry to RUN.

## Operation
- **Reset.** All outputs 0, STATE=IDLE, timer, error counter and retry counter cleared.
- **IDLE.**
  - Outputs low.
  - ENABLE=1 → PWRUP; timer loads C_PWR_CYC-1; FRAME_CNT and RETRY_CNT clear.
- **PWROFF.**
  - SENSOR_PWR_EN=0.
  - Timer expiry (timer==0) → PWRUP; timer reloads C_PWR_CYC-1.
- **PWRUP.**
  - SENSOR_PWR_EN=1.
  - Timer expiry → CONFIG; CONFIG_EN pulses in the transition cycle; timer loads C_CFG_TO_CYC-1.
- **CONFIG.**
  - CONFIG_DONE → WAIT_FRAME; timer loads C_FRAME_TO_CYC-1.
  - Timer expiry → FAIL.
- **WAIT_FRAME.**
  - FRAME_START → RUN; RETRY_CNT clears; error counter clears; timer reloads; FRAME_CNT increments.
  - Timer expiry → FAIL.
- **RUN.**
  - LINK_UP=1.
  - FRAME_START: timer reloads, FRAME_CNT increments, error counter := ERROR_IN (same-cycle error counts toward the new frame).
  - ERROR_IN without FRAME_START: error counter +1. Reaching C_ERR_LIMIT → FAIL.
  - Timer expiry → FAIL.
  - CFG_REQ → CONFIG with a CONFIG_EN pulse; SENSOR_PWR_EN stays 1.
- **FAIL (transition, not a state).**
  - RETRY_CNT+1.
  - If the new value equals C_MAX_RETRY → FAULT.
  - Otherwise → PWROFF, timer loads C_PWR_CYC-1.
- **FAULT.**
  - SENSOR_PWR_EN=0, FAULT=1; RETRY_CNT holds.
  - Exit only via ENABLE=0 → IDLE.
- **Priority within a cycle:** ENABLE=0 (any state → IDLE next cycle, power off immediately) > timer expiry / error limit > CFG_REQ > CONFIG_DONE / FRAME_START.
- **Ignored inputs:**
  - CONFIG_DONE outside CONFIG.
  - FRAME_START outside WAIT_FRAME and RUN.
  - ERROR_IN outside RUN.
  - CFG_REQ outside RUN.

## Timing
- Outputs are registered and decoded from the state register, so each changes in the cycle after the causing edge.
- CONFIG_EN is exactly one cycle wide, asserted with STATE=CONFIG in the first CONFIG cycle.
- **ENABLE rise to CONFIG_EN:** C_PWR_CYC+1 cycles.
- **Timer behaviour:** the timer counts down once per cycle; expiry is the cycle in which it reads 0, so a state lasts exactly N cycles for a load of N-1.
- **CONFIG_DONE coincident with CONFIG expiry:** expiry wins (FAIL).
- **FRAME_START coincident with watchdog expiry in RUN:** expiry wins.
- **FRAME_CNT and RETRY_CNT** update in the cycle of the triggering event and are visible next cycle.
- **Reset during any state:** immediate return to reset values, asynchronously.

## Test plan
(Small parameters: C_PWR_CYC=8, C_CFG_TO_CYC=20, C_FRAME_TO_CYC=50, C_ERR_LIMIT=3, C_MAX_RETRY=2.)
- **Nominal bring-up.** ENABLE=1, CONFIG_DONE 5 cycles after CONFIG_EN, FRAME_START 10 cycles later → CONFIG_EN 9 cycles after ENABLE, LINK_UP=1, FRAME_CNT=1, RETRY_CNT=0.
- **Config timeout.** CONFIG_DONE is never sent → CONFIG lasts 20 cycles, then PWROFF (8 cycles, PWR_EN=0), RETRY_CNT=1. The second timeout gives FAULT=1, RETRY_CNT=2, PWR_EN=0. ENABLE=0 → IDLE.
- **Error limit.** In RUN, 3 ERROR_IN pulses between frames → third pulse forces PWROFF, LINK_UP drops. Also verify that 2 pulses, then FRAME_START, then 2 pulses keeps RUN.
- **Watchdog.** In RUN, FRAME_START every 40 cycles holds RUN. Stopping frames drops LINK_UP exactly 50 cycles after the last FRAME_START.
- **Reconfigure.** CFG_REQ in RUN → single CONFIG_EN pulse, SENSOR_PWR_EN never drops, FRAME_CNT is preserved and increments on the next frame.
- **Abort and reset.** ENABLE=0 in PWRUP, CONFIG, and RUN → IDLE next cycle, all flags 0. RESET_N asserted asynchronously mid-timer → outputs 0 without waiting for a clock edge.
